// File: rtl/config_checker_pkg.sv
// rtl/config_checker_pkg.sv - shared state encoding and constants for the configuration chain checker
package config_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Wide all-ones value; callers size-cast it to their own field width.
    localparam logic [63:0] ALL_ONES = '1;

endpackage

// File: rtl/prog_clk_sampler.sv
// rtl/prog_clk_sampler.sv - aligned synchronizers for prog_clk/prog_reset/ccff_tail plus falling-edge sample strobe
module prog_clk_sampler
    import config_checker_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic prog_clk,
    input  logic prog_reset,
    input  logic ccff_tail,
    output logic sample_strobe,
    output logic tail_sample,
    output logic prog_reset_sync
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] tail_sync;
    logic                   clk_prev;

    // Identical depth on all three paths keeps tail data aligned with the clock edge it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            rst_sync  <= '0;
            tail_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], prog_clk};
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], prog_reset};
            tail_sync <= {tail_sync[SYNC_STAGES-2:0], ccff_tail};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sample_strobe   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign tail_sample     = tail_sync[SYNC_STAGES-1];
    assign prog_reset_sync = rst_sync[SYNC_STAGES-1];

endmodule

// File: rtl/config_chain_checker.sv
// rtl/config_chain_checker.sv - compares sampled ccff_tail against expected bitstream; watchdog under CONFIG_CHECKER_TIMEOUT_EN
module config_chain_checker
    import config_checker_pkg::*;
#(
    parameter int CHAIN_LENGTH   = 1024,
    parameter int SKIP_BITS      = 1024,
    parameter int ADDR_WIDTH     = 16,
    parameter int ERR_CNT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     prog_reset,
    input  logic                     prog_clk,
    input  logic                     ccff_tail,
    output logic [ADDR_WIDTH-1:0]    exp_addr,
    input  logic                     exp_bit,
    output logic                     check_done,
    output logic                     check_pass,
    output logic [ERR_CNT_WIDTH-1:0] error_count,
    output logic [ADDR_WIDTH-1:0]    first_error_addr,
    output logic                     timeout
);

    localparam int SKIP_W = (SKIP_BITS > 1) ? $clog2(SKIP_BITS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_NONE = ADDR_WIDTH'(ALL_ONES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CHAIN_LENGTH - 1);
    localparam logic [SKIP_W-1:0]     SKIP_LAST = SKIP_W'(SKIP_BITS - 1);

    logic sample_strobe;
    logic tail_sample;
    logic prog_reset_sync;

    prog_clk_sampler u_sampler (
        .clk             (sys_clk),
        .rst_n           (sys_rst_n),
        .prog_clk        (prog_clk),
        .prog_reset      (prog_reset),
        .ccff_tail       (ccff_tail),
        .sample_strobe   (sample_strobe),
        .tail_sample     (tail_sample),
        .prog_reset_sync (prog_reset_sync)
    );

    state_t                   state, state_n;
    logic [SKIP_W-1:0]        skip_cnt, skip_n;
    logic [ADDR_WIDTH-1:0]    addr_n, first_n;
    logic [ERR_CNT_WIDTH-1:0] err_n;
    logic                     done_n, pass_n, mismatch;

`ifdef CONFIG_CHECKER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt, wd_n;
    logic            to_n;
`endif

    always_comb begin
        state_n  = state;
        skip_n   = skip_cnt;
        addr_n   = exp_addr;
        err_n    = error_count;
        first_n  = first_error_addr;
        done_n   = check_done;
        pass_n   = check_pass;
        mismatch = tail_sample ^ exp_bit;
`ifdef CONFIG_CHECKER_TIMEOUT_EN
        wd_n     = '0;
        to_n     = timeout;
`endif
        if (prog_reset_sync) begin
            state_n = IDLE;
            skip_n  = '0;
            addr_n  = '0;
            err_n   = '0;
            first_n = ADDR_NONE;
            done_n  = 1'b0;
            pass_n  = 1'b0;
`ifdef CONFIG_CHECKER_TIMEOUT_EN
            to_n    = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state_n = (SKIP_BITS > 0) ? SKIP : COMPARE;
                SKIP: begin
                    if (sample_strobe) begin
                        if (skip_cnt == SKIP_LAST) begin
                            state_n = COMPARE;
                            skip_n  = '0;
                        end else begin
                            skip_n = skip_cnt + 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    if (sample_strobe) begin
                        // A saturated counter means an earlier mismatch already owns first_error_addr.
                        if (mismatch) begin
                            if (error_count != '1) err_n = error_count + 1'b1;
                            if (error_count == '0) first_n = exp_addr;
                        end
                        if (exp_addr == ADDR_LAST) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            pass_n  = !mismatch && (error_count == '0);
                        end else begin
                            addr_n = exp_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
`ifdef CONFIG_CHECKER_TIMEOUT_EN
            if ((state == SKIP || state == COMPARE) && !sample_strobe) begin
                if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    pass_n  = 1'b0;
                    to_n    = 1'b1;
                end else begin
                    wd_n = wd_cnt + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= IDLE;
            skip_cnt         <= '0;
            exp_addr         <= '0;
            error_count      <= '0;
            first_error_addr <= ADDR_NONE;
            check_done       <= 1'b0;
            check_pass       <= 1'b0;
        end else begin
            state            <= state_n;
            skip_cnt         <= skip_n;
            exp_addr         <= addr_n;
            error_count      <= err_n;
            first_error_addr <= first_n;
            check_done       <= done_n;
            check_pass       <= pass_n;
        end
    end

`ifdef CONFIG_CHECKER_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= wd_n;
            timeout <= to_n;
        end
    end
`else
    // No watchdog in this build; the comparison is constant false for any legal TIMEOUT_CYCLES.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
